rr_select_4ch: RTL and testbench

- Upstream control stage for the 4-to-1 behavioural multiplexer: arbitrates four request lines round-robin and drives the mux's 2-bit select.
- Grant is held until the consumer signals done, the requester withdraws, or a hold timeout expires.
- Outputs are registered, so the mux select is glitch-free and stable for the whole grant.

---
 rtl/rr_select_4ch_pkg.sv | 13 +
 rtl/rr_pick4.sv | 26 ++
 rtl/rr_select_4ch.sv | 73 +++++++
 tb/tb_rr_select_4ch.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rr_select_4ch_pkg.sv
// Shared definitions for the four-channel round-robin select stage.
package rr_select_4ch_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } rr_state_t;

    localparam int unsigned HOLD_MAX_DEFAULT = 15;
    localparam int unsigned CW_DEFAULT       = 4;
    localparam int unsigned NUM_CH           = 4;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or after ptr, mod 4.
module rr_pick4
    import rr_select_4ch_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);

    logic [1:0] pos;

    always_comb begin
        idx = 2'd0;
        pos = 2'd0;
        any = |req;
        // Scan from the farthest offset down so the nearest set bit wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            pos = ptr + 2'(k);
            if (req[pos]) begin
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/rr_select_4ch.sv
// Round-robin arbiter driving a 4:1 mux select; grants end on done, withdrawal or hold timeout.
module rr_select_4ch
    import rr_select_4ch_pkg::*;
#(
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
    parameter int unsigned CW       = CW_DEFAULT
) (
    input  logic       clock,
    input  logic       reset_b,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid,
    output logic       timeout
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    rr_state_t   state;
    logic [1:0]  ptr;
    logic [CW-1:0] cnt;
    logic [1:0]  pick_idx;
    logic        pick_any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state   <= ST_IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            sel     <= 2'd0;
            grant   <= 4'b0000;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        sel   <= pick_idx;
                        grant <= 4'b0001 << pick_idx;
                        valid <= 1'b1;
                        cnt   <= '0;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // done and withdrawal outrank the timeout, so no pulse when they coincide.
                    if (done || !req[sel] || (cnt == HOLD_LAST)) begin
                        grant   <= 4'b0000;
                        valid   <= 1'b0;
                        ptr     <= sel + 2'd1;
                        state   <= ST_IDLE;
                        timeout <= !done && req[sel];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_select_4ch.sv
// Directed self-checking bench for rr_select_4ch with default HOLD_MAX=15.
module tb_rr_select_4ch;

    logic       clock;
    logic       reset_b;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    rr_select_4ch dut (
        .clock   (clock),
        .reset_b (reset_b),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .grant   (grant),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_sel, input logic [3:0] e_grant,
                             input logic e_valid, input logic e_timeout);
        check({tag, ".sel"}, {6'd0, sel}, {6'd0, e_sel});
        check({tag, ".grant"}, {4'd0, grant}, {4'd0, e_grant});
        check({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
        check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_timeout});
    endtask

    initial begin
        int vcycles;
        logic [3:0] one_hot;

        reset_b = 1'b0;
        req     = 4'b0000;
        done    = 1'b0;
        step();
        step();
        reset_b = 1'b1;
        check_out("reset", 2'b00, 4'b0000, 1'b0, 1'b0);

        // Single requester, released by done.
        req = 4'b0100;
        step();
        check_out("t1_grant", 2'b10, 4'b0100, 1'b1, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        check_out("t1_release", 2'b10, 4'b0000, 1'b0, 1'b0);
        step();
        check_out("t1_idle_hold", 2'b10, 4'b0000, 1'b0, 1'b0);

        // Rotation with all requesting; reset first so ptr starts at 0.
        reset_b = 1'b0;
        step();
        reset_b = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            one_hot = 4'b0001 << (i % 4);
            check_out($sformatf("t2_grant%0d", i), 2'(i % 4), one_hot, 1'b1, 1'b0);
            done = 1'b1;
            step();
            done = 1'b0;
            check_out($sformatf("t2_gap%0d", i), 2'(i % 4), 4'b0000, 1'b0, 1'b0);
        end
        req = 4'b0000;
        step();

        // Hold timeout with a lone requester.
        req = 4'b0001;
        step();
        check_out("t3_grant", 2'b00, 4'b0001, 1'b1, 1'b0);
        vcycles = 1;
        while (vcycles < 40) begin
            step();
            if (!valid) break;
            vcycles++;
        end
        check("t3_valid_cycles", 8'(vcycles), 8'd15);
        check_out("t3_timeout", 2'b00, 4'b0000, 1'b0, 1'b1);
        step();
        check_out("t3_regrant", 2'b00, 4'b0001, 1'b1, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        check_out("t3_release", 2'b00, 4'b0000, 1'b0, 1'b0);

        // Withdrawal of req[sel]; ptr is 1, so 0100 grants channel 2.
        req = 4'b0100;
        step();
        check_out("t4_grant2", 2'b10, 4'b0100, 1'b1, 1'b0);
        req = 4'b1011;
        step();
        check_out("t4_withdraw", 2'b10, 4'b0000, 1'b0, 1'b0);
        step();
        check_out("t4_grant3", 2'b11, 4'b1000, 1'b1, 1'b0);
        req = 4'b1001;
        step();
        check_out("t4_other_req", 2'b11, 4'b1000, 1'b1, 1'b0);

        // Reset mid-grant of channel 3.
        reset_b = 1'b0;
        req     = 4'b1010;
        step();
        reset_b = 1'b1;
        check_out("t5_reset", 2'b00, 4'b0000, 1'b0, 1'b0);
        step();
        check_out("t5_grant1", 2'b01, 4'b0010, 1'b1, 1'b0);

        // done coinciding with the timeout edge (15th valid cycle).
        for (int i = 0; i < 14; i++) begin
            step();
            check($sformatf("t6_hold%0d", i), {7'd0, valid}, 8'd1);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 4'b0000;
        check_out("t6_done_wins", 2'b01, 4'b0000, 1'b0, 1'b0);

        // done while idle is ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        check_out("t7_idle_done", 2'b01, 4'b0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
